// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Producer end of the 13-bit processor instruction bus {op, reg, addr}.
//   The host loads a small program buffer. On start, the sequencer issues one
//   buffered word per clock. Issue can be stalled with pause or cancelled with
//   abort. When nothing is being issued, the bus keeps the last issued word.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   prog_we/addr/   program buffer write port; writes are ignored while in RUN
//   prog_data
//   prog_len        number of words to run; sampled on start and clamped to DEPTH
//   start           begin execution from entry 0 (only accepted in IDLE)
//   pause           hold issue while high
//   abort           return to IDLE at once; takes priority over pause and issue
//   instruction     registered instruction word sent to the processor
//   instr_valid     high when the last edge issued a new word
//   busy            high in RUN and DONE
//   done            one-cycle pulse when the program has finished
//   pc              index of the next entry to issue
//   issue_count     number of words issued since reset (wraps)
module instr_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             prog_we,
   input  logic [AW-1:0]    prog_addr,
   input  logic [12:0]      prog_data,
   input  logic [AW:0]      prog_len,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   output logic [12:0]      instruction,
   output logic             instr_valid,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    pc,
   output logic [CNT_W-1:0] issue_count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

   state_t      state, state_d;
   logic [AW:0] len_q;
   logic [AW:0] len_clamp;
   logic        issue;
   logic        last;
   logic [12:0] mem [DEPTH];

   assign len_clamp = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
   // len_q is never 0 in RUN, so len_q-1 cannot underflow in this comparison.
   assign last      = ({1'b0, pc} == (len_q - 1'b1));

   // Next-state logic and issue decision
   always_comb begin
      state_d = state;
      issue   = 1'b0;
      case (state)
         IDLE: if (start) state_d = (prog_len == '0) ? DONE : RUN;
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (!pause) begin
               issue = 1'b1;
               if (last) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         instruction <= '0;
         instr_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pc          <= '0;
         issue_count <= '0;
         len_q       <= '0;
      end else begin
         state <= state_d;
         busy  <= (state_d != IDLE);
         done  <= (state_d == DONE);
         case (state)
            IDLE: begin
               instr_valid <= 1'b0;
               if (start) begin
                  pc    <= '0;
                  len_q <= len_clamp;
               end
            end
            RUN: begin
               if (abort) begin
                  instr_valid <= 1'b0;
                  pc          <= '0;
               end else if (issue) begin
                  instruction <= mem[pc];
                  instr_valid <= 1'b1;
                  pc          <= pc + 1'b1;   // wraps to 0 after a full-buffer run
                  issue_count <= issue_count + 1'b1;
               end else begin
                  instr_valid <= 1'b0;        // paused: word and pc held
               end
            end
            // The final word stays valid through DONE and drops on the way back to IDLE.
            DONE:    instr_valid <= 1'b0;
            default: instr_valid <= 1'b0;
         endcase
      end
   end

   // The program buffer is not reset. Its contents survive reset and reruns.
   always_ff @(posedge clk) begin
      if (prog_we && state != RUN) mem[prog_addr] <= prog_data;
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer. Expected values are hand-computed.
module tb_instr_sequencer;
   localparam int DEPTH = 16, AW = 4, CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             prog_we;
   logic [AW-1:0]    prog_addr;
   logic [12:0]      prog_data;
   logic [AW:0]      prog_len;
   logic             start, pause, abort;
   logic [12:0]      instruction;
   logic             instr_valid, busy, done;
   logic [AW-1:0]    pc;
   logic [CNT_W-1:0] issue_count;

   int compared = 0;
   int mismatched = 0;

   instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_len(prog_len), .start(start), .pause(pause),
      .abort(abort), .instruction(instruction), .instr_valid(instr_valid),
      .busy(busy), .done(done), .pc(pc), .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check instruction, instr_valid, busy and done together.
   task automatic chk_out(input string tag, input logic [12:0] ins, input logic v,
                          input logic b, input logic d);
      chk({tag, ".instr"}, 32'(instruction), 32'(ins));
      chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
      chk({tag, ".busy"},  32'(busy), 32'(b));
      chk({tag, ".done"},  32'(done), 32'(d));
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [12:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic do_start(input logic [AW:0] len);
      prog_len = len; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      prog_len = '0; start = 1'b0; pause = 1'b0; abort = 1'b0;
      tick(); tick();
      chk_out("rst0", 13'h0, 1'b0, 1'b0, 1'b0);
      chk("rst0.pc", 32'(pc), 32'd0);
      chk("rst0.cnt", 32'(issue_count), 32'd0);
      rst = 1'b1;
      tick();

      // Basic 3-word program
      load(4'd0, 13'h0005); load(4'd1, 13'h0A01); load(4'd2, 13'h1000);
      do_start(5'd3);
      chk_out("t2.k", 13'h0, 1'b0, 1'b1, 1'b0);
      tick(); chk_out("t2.w0", 13'h0005, 1'b1, 1'b1, 1'b0);
      chk("t2.pc1", 32'(pc), 32'd1);
      tick(); chk_out("t2.w1", 13'h0A01, 1'b1, 1'b1, 1'b0);
      tick(); chk_out("t2.w2", 13'h1000, 1'b1, 1'b1, 1'b1);
      chk("t2.cnt", 32'(issue_count), 32'd3);
      tick(); chk_out("t2.idle", 13'h1000, 1'b0, 1'b0, 1'b0);
      tick(); chk_out("t2.idle2", 13'h1000, 1'b0, 1'b0, 1'b0);

      // Pause for two cycles after the first issue
      do_start(5'd3);
      tick(); chk_out("t3.w0", 13'h0005, 1'b1, 1'b1, 1'b0);
      pause = 1'b1;
      tick(); chk_out("t3.p1", 13'h0005, 1'b0, 1'b1, 1'b0);
      chk("t3.pcp", 32'(pc), 32'd1);
      tick(); chk_out("t3.p2", 13'h0005, 1'b0, 1'b1, 1'b0);
      pause = 1'b0;
      tick(); chk_out("t3.w1", 13'h0A01, 1'b1, 1'b1, 1'b0);
      tick(); chk_out("t3.w2", 13'h1000, 1'b1, 1'b1, 1'b1);
      chk("t3.cnt", 32'(issue_count), 32'd6);
      tick(); chk_out("t3.idle", 13'h1000, 1'b0, 1'b0, 1'b0);

      // Abort after the second issue; abort wins over pause
      do_start(5'd3);
      tick(); chk_out("t4.w0", 13'h0005, 1'b1, 1'b1, 1'b0);
      tick(); chk_out("t4.w1", 13'h0A01, 1'b1, 1'b1, 1'b0);
      abort = 1'b1; pause = 1'b1;
      tick(); chk_out("t4.ab", 13'h0A01, 1'b0, 1'b0, 1'b0);
      chk("t4.pc", 32'(pc), 32'd0);
      chk("t4.cnt", 32'(issue_count), 32'd8);
      abort = 1'b0; pause = 1'b0;
      tick(); tick(); chk_out("t4.quiet", 13'h0A01, 1'b0, 1'b0, 1'b0);
      chk("t4.cnt2", 32'(issue_count), 32'd8);
      // Zero-length program
      do_start(5'd0);
      chk_out("t4.z", 13'h0A01, 1'b0, 1'b1, 1'b1);
      tick(); chk_out("t4.z2", 13'h0A01, 1'b0, 1'b0, 1'b0);
      chk("t4.zcnt", 32'(issue_count), 32'd8);

      // Full buffer with an oversized length, plus a write attempt during RUN
      for (int i = 0; i < DEPTH; i++) load(AW'(i), 13'h100 + 13'(i));
      do_start(5'd19);
      prog_we = 1'b1; prog_addr = 4'd0; prog_data = 13'h1FFF;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         chk_out($sformatf("t5.w%0d", i), 13'h100 + 13'(i), 1'b1, 1'b1, i == DEPTH-1);
      end
      prog_we = 1'b0;
      chk("t5.pcwrap", 32'(pc), 32'd0);
      chk("t5.cnt", 32'(issue_count), 32'd24);
      tick(); chk_out("t5.idle", 13'h10F, 1'b0, 1'b0, 1'b0);
      do_start(5'd1);
      tick(); chk_out("t5.rerun", 13'h100, 1'b1, 1'b1, 1'b1);
      tick();

      // Asynchronous reset in the middle of a run
      do_start(5'd16);
      tick(); tick();
      chk_out("t1.pre", 13'h101, 1'b1, 1'b1, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk_out("t1.async", 13'h0, 1'b0, 1'b0, 1'b0);
      chk("t1.pc", 32'(pc), 32'd0);
      chk("t1.cnt", 32'(issue_count), 32'd0);
      tick();
      rst = 1'b1;
      tick(); chk_out("t1.idle", 13'h0, 1'b0, 1'b0, 1'b0);
      do_start(5'd2);
      tick(); chk_out("t1.keep0", 13'h100, 1'b1, 1'b1, 1'b0);
      tick(); chk_out("t1.keep1", 13'h101, 1'b1, 1'b1, 1'b1);
      chk("t1.cnt2", 32'(issue_count), 32'd2);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
